// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter family.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Number of baud ticks one frame occupies on the line: start, data, optional parity, stop bits.
  function automatic int frameTicks(input int dataBits, input int parityMode, input int stopBits);
    return 1 + dataBits + ((parityMode != PAR_NONE) ? 1 : 0) + stopBits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO that queues words for the transmitter; read data is valid in the pop cycle.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wrData,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdData,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             w_doPush;
  logic             w_doPop;

  // Fullness is judged before any pop in the same cycle, so a write to a full FIFO is always dropped.
  assign o_full     = (r_count == FULL_COUNT);
  assign o_empty    = (r_count == '0);
  assign w_doPush   = i_push && !o_full;
  assign w_doPop    = i_pop && !o_empty;
  assign o_rdData   = r_mem[r_rdPtr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // Storage array carries no reset; only the pointers and count define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; overflow is a one-cycle pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_push && o_full;
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: input FIFO feeding a frame FSM with optional parity and 1-2 stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk_50m,
  input  logic                              rst,
  input  logic                              clken,
  input  logic [DATA_BITS-1:0]              data_in,
  input  logic                              wr_en,
  output logic                              full,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              Tx,
  output logic                              Tx_busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [0:0]       STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bitIdx;
  logic [0:0]           r_stopCnt;
  logic                 r_parity;
  logic                 r_tx;

  tx_state_t            w_nextState;
  logic [DATA_BITS-1:0] w_nextShift;
  logic [IDX_W-1:0]     w_nextBitIdx;
  logic [0:0]           w_nextStopCnt;
  logic                 w_nextParity;
  logic                 w_nextTx;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_fifoData;
  logic                 w_fifoEmpty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk_50m),
    .i_rst      (rst),
    .i_push     (wr_en),
    .i_wrData   (data_in),
    .i_pop      (w_pop),
    .o_rdData   (w_fifoData),
    .o_full     (full),
    .o_empty    (w_fifoEmpty),
    .o_count    (fifo_count),
    .o_overflow (overflow)
  );

  assign Tx      = r_tx;
  assign Tx_busy = (r_state != IDLE);

  // Frame registers; reset aborts any frame in flight and returns the line to idle-high at once.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bitIdx  <= '0;
      r_stopCnt <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_shift   <= w_nextShift;
      r_bitIdx  <= w_nextBitIdx;
      r_stopCnt <= w_nextStopCnt;
      r_parity  <= w_nextParity;
      r_tx      <= w_nextTx;
    end
  end

  // Next-state logic: IDLE pops without waiting for a tick, every other line change waits for clken.
  always_comb begin
    w_nextState   = r_state;
    w_nextShift   = r_shift;
    w_nextBitIdx  = r_bitIdx;
    w_nextStopCnt = r_stopCnt;
    w_nextParity  = r_parity;
    w_nextTx      = r_tx;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifoEmpty) begin
          w_pop         = 1'b1;
          w_nextShift   = w_fifoData;
          w_nextBitIdx  = '0;
          w_nextStopCnt = '0;
          w_nextParity  = (^w_fifoData) ^ (PARITY_MODE == PAR_ODD);
          w_nextState   = START;
        end
      end
      START: begin
        if (clken) begin
          w_nextTx    = 1'b0;
          w_nextState = DATA;
        end
      end
      DATA: begin
        if (clken) begin
          w_nextTx    = r_shift[0];
          w_nextShift = r_shift >> 1;
          if (r_bitIdx == IDX_LAST) begin
            w_nextState = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          end else begin
            w_nextBitIdx = r_bitIdx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (clken) begin
          w_nextTx    = r_parity;
          w_nextState = STOP;
        end
      end
      STOP: begin
        if (clken) begin
          w_nextTx = 1'b1;
          if (r_stopCnt == STOP_LAST) begin
            w_nextState = IDLE;
          end else begin
            w_nextStopCnt = r_stopCnt + 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param using three configurations: 8N1, 7E2 and 8O1, all with a 4-deep FIFO.
module tb_uart_tx_param;

  logic       clk_50m;
  logic       rst;
  logic       clken;
  logic       clkenOn;
  int         tickPhase;

  logic [7:0] data0;
  logic [6:0] data1;
  logic [7:0] data2;
  logic       wrEn0, wrEn1, wrEn2;
  logic       full0, full1, full2;
  logic       ovf0, ovf1, ovf2;
  logic [2:0] count0, count1, count2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;

  int testsRun;
  int failCount;

  typedef struct {
    int         dut;
    logic [8:0] data;
    string      exp;
  } vec_t;

  vec_t vecs[8];

  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut8n1 (
    .clk_50m(clk_50m), .rst(rst), .clken(clken), .data_in(data0), .wr_en(wrEn0),
    .full(full0), .overflow(ovf0), .fifo_count(count0), .Tx(tx0), .Tx_busy(busy0));

  uart_tx_param #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut7e2 (
    .clk_50m(clk_50m), .rst(rst), .clken(clken), .data_in(data1), .wr_en(wrEn1),
    .full(full1), .overflow(ovf1), .fifo_count(count1), .Tx(tx1), .Tx_busy(busy1));

  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut8o1 (
    .clk_50m(clk_50m), .rst(rst), .clken(clken), .data_in(data2), .wr_en(wrEn2),
    .full(full2), .overflow(ovf2), .fifo_count(count2), .Tx(tx2), .Tx_busy(busy2));

  // 50 MHz system clock.
  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  // Baud tick every fourth cycle while enabled, changed on the falling edge.
  initial begin
    clken     = 1'b0;
    tickPhase = 0;
    forever begin
      @(negedge clk_50m);
      tickPhase = (tickPhase + 1) % 4;
      clken     = clkenOn && (tickPhase == 0);
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic getTx(input int d);
    case (d)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic getBusy(input int d);
    case (d)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic [2:0] getCount(input int d);
    case (d)
      0:       return count0;
      1:       return count1;
      default: return count2;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic setWrite(input int d, input logic [8:0] data, input logic en);
    case (d)
      0: begin wrEn0 = en; data0 = data[7:0]; end
      1: begin wrEn1 = en; data1 = data[6:0]; end
      default: begin wrEn2 = en; data2 = data[7:0]; end
    endcase
  endtask

  // Wait for the next rising edge that carries a baud tick, then settle past it.
  task automatic waitTick();
    bit hit;
    hit = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk_50m);
      if (clken) begin
        hit = 1;
        break;
      end
    end
    #1;
    if (!hit) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL tick timeout: no clken within 16 cycles");
    end
  endtask

  // Compare the line after each tick against a string of expected bits; busy drops on each frame's last tick.
  task automatic captureBits(input int d, input string exp, input int frameLen, input string tag);
    for (int i = 0; i < exp.len(); i++) begin
      waitTick();
      checkOutput($sformatf("%s tick%0d Tx", tag, i), {31'd0, getTx(d)}, {31'd0, exp[i] == 8'h31});
      checkOutput($sformatf("%s tick%0d Tx_busy", tag, i), {31'd0, getBusy(d)},
                  {31'd0, ((i + 1) % frameLen) != 0});
    end
  endtask

  // Queue one word with ticks held off, check enqueue/pop latency, then let the frame run.
  task automatic applyStimulus(input int d, input logic [8:0] data, input string exp, input string tag);
    clkenOn = 1'b0;
    @(negedge clk_50m);
    setWrite(d, data, 1'b1);
    @(posedge clk_50m);
    #1;
    checkOutput({tag, " count after write"}, {29'd0, getCount(d)}, 32'd1);
    @(negedge clk_50m);
    setWrite(d, data, 1'b0);
    @(posedge clk_50m);
    #1;
    checkOutput({tag, " count after pop"}, {29'd0, getCount(d)}, 32'd0);
    checkOutput({tag, " busy after pop"}, {31'd0, getBusy(d)}, 32'd1);
    repeat (2) @(negedge clk_50m);
    clkenOn = 1'b1;
    captureBits(d, exp, exp.len(), tag);
  endtask

  localparam string F11 = "0100010001";
  localparam string F22 = "0010001001";
  localparam string F33 = "0110011001";
  localparam string F44 = "0001000101";
  localparam string F55 = "0101010101";

  initial begin
    logic [8:0] burst [5];
    logic [2:0] expCount [5];
    logic       expFull [5];
    logic       expOvf [5];

    testsRun  = 0;
    failCount = 0;
    clkenOn   = 1'b0;
    rst       = 1'b1;
    wrEn0 = 1'b0; wrEn1 = 1'b0; wrEn2 = 1'b0;
    data0 = '0;   data1 = '0;   data2 = '0;

    vecs[0] = '{dut: 0, data: 9'h0A5, exp: "0101001011"};
    vecs[1] = '{dut: 0, data: 9'h000, exp: "0000000001"};
    vecs[2] = '{dut: 0, data: 9'h0FF, exp: "0111111111"};
    vecs[3] = '{dut: 1, data: 9'h007, exp: "01110000111"};
    vecs[4] = '{dut: 1, data: 9'h000, exp: "00000000011"};
    vecs[5] = '{dut: 2, data: 9'h03C, exp: "00011110011"};
    vecs[6] = '{dut: 2, data: 9'h001, exp: "01000000001"};
    vecs[7] = '{dut: 2, data: 9'h080, exp: "00000000101"};

    // Reset state.
    repeat (3) @(posedge clk_50m);
    #1;
    checkOutput("reset Tx 8N1", {31'd0, tx0}, 32'd1);
    checkOutput("reset Tx 7E2", {31'd0, tx1}, 32'd1);
    checkOutput("reset Tx 8O1", {31'd0, tx2}, 32'd1);
    checkOutput("reset busy", {31'd0, busy0}, 32'd0);
    checkOutput("reset count", {29'd0, count0}, 32'd0);
    checkOutput("reset full", {31'd0, full0}, 32'd0);
    checkOutput("reset overflow", {31'd0, ovf0}, 32'd0);
    @(negedge clk_50m);
    rst = 1'b0;

    // Single frames across the three configurations.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].dut, vecs[v].data, vecs[v].exp, $sformatf("vec%0d", v));
    end

    // 7E2 back-to-back: second start bit lands on the tick right after the second stop bit.
    clkenOn = 1'b0;
    @(negedge clk_50m);
    setWrite(1, 9'h007, 1'b1);
    @(negedge clk_50m);
    setWrite(1, 9'h055, 1'b1);
    @(negedge clk_50m);
    setWrite(1, 9'h055, 1'b0);
    repeat (2) @(negedge clk_50m);
    clkenOn = 1'b1;
    captureBits(1, "0111000011101010101011", 11, "b2b7e2");

    // FIFO fill with ticks held off: the first word parks in START, the next four fill the FIFO.
    burst[0] = 9'h022; burst[1] = 9'h033; burst[2] = 9'h044; burst[3] = 9'h055; burst[4] = 9'h066;
    expCount[0] = 3'd1; expCount[1] = 3'd2; expCount[2] = 3'd3; expCount[3] = 3'd4; expCount[4] = 3'd4;
    expFull[0] = 1'b0; expFull[1] = 1'b0; expFull[2] = 1'b0; expFull[3] = 1'b1; expFull[4] = 1'b1;
    expOvf[0] = 1'b0; expOvf[1] = 1'b0; expOvf[2] = 1'b0; expOvf[3] = 1'b0; expOvf[4] = 1'b1;
    clkenOn = 1'b0;
    @(negedge clk_50m);
    setWrite(0, 9'h011, 1'b1);
    @(negedge clk_50m);
    setWrite(0, 9'h011, 1'b0);
    repeat (2) @(negedge clk_50m);
    for (int k = 0; k < 5; k++) begin
      setWrite(0, burst[k], 1'b1);
      @(posedge clk_50m);
      #1;
      checkOutput($sformatf("fill%0d count", k), {29'd0, count0}, {29'd0, expCount[k]});
      checkOutput($sformatf("fill%0d full", k), {31'd0, full0}, {31'd0, expFull[k]});
      checkOutput($sformatf("fill%0d overflow", k), {31'd0, ovf0}, {31'd0, expOvf[k]});
      @(negedge clk_50m);
    end
    setWrite(0, 9'h000, 1'b0);
    @(posedge clk_50m);
    #1;
    checkOutput("overflow pulse ends", {31'd0, ovf0}, 32'd0);
    checkOutput("count holds when full", {29'd0, count0}, 32'd4);
    @(negedge clk_50m);
    clkenOn = 1'b1;
    captureBits(0, {F11, F22, F33, F44, F55}, 10, "drain");
    checkOutput("drain count", {29'd0, count0}, 32'd0);
    checkOutput("drain full", {31'd0, full0}, 32'd0);

    // Reset during DATA bit 3 with a word still queued.
    clkenOn = 1'b0;
    @(negedge clk_50m);
    setWrite(0, 9'h0A5, 1'b1);
    @(negedge clk_50m);
    setWrite(0, 9'h0A5, 1'b0);
    @(negedge clk_50m);
    setWrite(0, 9'h00F, 1'b1);
    @(negedge clk_50m);
    setWrite(0, 9'h00F, 1'b0);
    @(negedge clk_50m);
    checkOutput("queued before reset", {29'd0, count0}, 32'd1);
    clkenOn = 1'b1;
    captureBits(0, "01010", 10, "prereset");
    rst = 1'b1;
    @(posedge clk_50m);
    #1;
    checkOutput("midframe reset Tx", {31'd0, tx0}, 32'd1);
    checkOutput("midframe reset count", {29'd0, count0}, 32'd0);
    checkOutput("midframe reset busy", {31'd0, busy0}, 32'd0);
    checkOutput("midframe reset full", {31'd0, full0}, 32'd0);
    rst = 1'b0;
    applyStimulus(0, 9'h05A, "0010110101", "postreset");

    // Push and pop in the same cycle with two words queued: count holds and order is kept.
    clkenOn = 1'b0;
    @(negedge clk_50m);
    setWrite(0, 9'h011, 1'b1);
    @(negedge clk_50m);
    setWrite(0, 9'h011, 1'b0);
    @(negedge clk_50m);
    setWrite(0, 9'h022, 1'b1);
    @(negedge clk_50m);
    setWrite(0, 9'h033, 1'b1);
    @(negedge clk_50m);
    setWrite(0, 9'h033, 1'b0);
    @(negedge clk_50m);
    checkOutput("pushpop pre count", {29'd0, count0}, 32'd2);
    clkenOn = 1'b1;
    captureBits(0, F11, 10, "pushpopA");
    setWrite(0, 9'h044, 1'b1);
    @(posedge clk_50m);
    #1;
    setWrite(0, 9'h044, 1'b0);
    checkOutput("pushpop count", {29'd0, count0}, 32'd2);
    checkOutput("pushpop busy", {31'd0, busy0}, 32'd1);
    captureBits(0, {F22, F33, F44}, 10, "pushpopBCD");
    checkOutput("pushpop final count", {29'd0, count0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
